// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the byte-lane enable helper.
package ahb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  // Byte enables for a transfer; any size of word or larger covers all lanes.
  function automatic logic [BE_W-1:0] be_calc(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [BE_W-1:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_sram_bridge_if.sv
// AHB-Lite slave bus plus SRAM port of the bridge.
interface ahb_sram_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                  HSEL;
  logic [31:0]           HADDR;
  logic                  HREADY;
  logic                  HWRITE;
  logic [1:0]            HTRANS;
  logic [2:0]            HSIZE;
  logic [31:0]           HWDATA;
  logic [31:0]           HRDATA;
  logic                  HREADYOUT;
  logic [31:0]           SRAMRDATA;
  logic [3:0]            SRAMWEN;
  logic [31:0]           SRAMWDATA;
  logic                  SRAMCS0;
  logic [ADDR_WIDTH-1:0] SRAMADDR;

  modport slave (
    input  HSEL, HADDR, HREADY, HWRITE, HTRANS, HSIZE, HWDATA, SRAMRDATA,
    output HRDATA, HREADYOUT, SRAMWEN, SRAMWDATA, SRAMCS0, SRAMADDR
  );

  modport master (
    output HSEL, HADDR, HREADY, HWRITE, HTRANS, HSIZE, HWDATA, SRAMRDATA,
    input  HRDATA, HREADYOUT, SRAMWEN, SRAMWDATA, SRAMCS0, SRAMADDR
  );
endinterface

// File: rtl/ahb_sram_wbuf.sv
// One-entry parked-write buffer with read-data merge.
module ahb_sram_wbuf
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic                  i_commit,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [BE_W-1:0]       i_be,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_dph_rd,
  input  logic [ADDR_WIDTH-1:0] i_dph_addr,
  input  logic [DATA_W-1:0]     i_sram_rdata,
  output logic                  o_pend,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [BE_W-1:0]       o_be,
  output logic [DATA_W-1:0]     o_data,
  output logic [DATA_W-1:0]     o_rdata
);

  logic                  r_pend;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [BE_W-1:0]       r_be;
  logic [DATA_W-1:0]     r_data;
  logic                  w_hit;

  // Pending flag: set on load, cleared by commit or reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend <= 1'b0;
    end else if (i_load) begin
      r_pend <= 1'b1;
    end else if (i_commit) begin
      r_pend <= 1'b0;
    end
  end

  // Buffer payload; contents are don't-care while not pending.
  always_ff @(posedge i_clk) begin
    if (i_load) begin
      r_addr <= i_addr;
      r_be   <= i_be;
      r_data <= i_data;
    end
  end

  assign w_hit = r_pend && (r_addr == i_dph_addr);

  // Read data: SRAM word with parked lanes overlaid when the address matches.
  always_comb begin
    o_rdata = '0;
    if (i_dph_rd) begin
      o_rdata = i_sram_rdata;
      for (int i = 0; i < int'(BE_W); i++) begin
        if (w_hit && r_be[i]) begin
          o_rdata[i*8 +: 8] = r_data[i*8 +: 8];
        end
      end
    end
  end

  assign o_pend = r_pend;
  assign o_addr = r_addr;
  assign o_be   = r_be;
  assign o_data = r_data;

endmodule

// File: rtl/ahb_sram_bridge.sv
// Zero-wait-state AHB-Lite to single-port SRAM bridge.
module ahb_sram_bridge
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic               HCLK,
  input  logic               HRESET,
  ahb_sram_bridge_if.slave   bus
);

  logic                  w_acc;
  logic                  w_rd_req;
  logic                  w_load;
  logic                  w_commit;
  logic [BE_W-1:0]       w_be;
  logic                  w_pend;
  logic [ADDR_WIDTH-1:0] w_buf_addr;
  logic [BE_W-1:0]       w_buf_be;
  logic [DATA_W-1:0]     w_buf_data;
  logic [DATA_W-1:0]     w_rdata;
  logic                  w_unused;

  logic                  r_dph_rd;
  logic                  r_dph_wr;
  logic [ADDR_WIDTH-1:0] r_dph_addr;
  logic [BE_W-1:0]       r_dph_be;

  assign w_acc    = bus.HSEL && bus.HREADY && bus.HTRANS[1];
  assign w_rd_req = w_acc && !bus.HWRITE;
  assign w_be     = be_calc(bus.HSIZE, bus.HADDR[1:0]);
  assign w_load   = r_dph_wr && w_rd_req && !HRESET;
  assign w_unused = ^{bus.HADDR[31:ADDR_WIDTH+2], bus.HTRANS[0]};

  // Address-phase capture for the following data phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_dph_rd   <= 1'b0;
      r_dph_wr   <= 1'b0;
      r_dph_addr <= '0;
      r_dph_be   <= '0;
    end else begin
      r_dph_rd   <= w_rd_req;
      r_dph_wr   <= w_acc && bus.HWRITE;
      r_dph_addr <= bus.HADDR[ADDR_WIDTH+1:2];
      r_dph_be   <= w_be;
    end
  end

  // A write data phase never coincides with a parked write.
  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      assert (!(w_pend && r_dph_wr));
    end
  end

  // SRAM port arbitration: read strobe, then buffer commit, then direct write.
  always_comb begin
    bus.SRAMCS0   = 1'b0;
    bus.SRAMWEN   = '0;
    bus.SRAMADDR  = '0;
    bus.SRAMWDATA = bus.HWDATA;
    w_commit      = 1'b0;
    if (!HRESET) begin
      if (w_rd_req) begin
        bus.SRAMCS0  = 1'b1;
        bus.SRAMADDR = bus.HADDR[ADDR_WIDTH+1:2];
      end else if (w_pend) begin
        bus.SRAMCS0   = 1'b1;
        bus.SRAMWEN   = w_buf_be;
        bus.SRAMADDR  = w_buf_addr;
        bus.SRAMWDATA = w_buf_data;
        w_commit      = 1'b1;
      end else if (r_dph_wr) begin
        bus.SRAMCS0  = 1'b1;
        bus.SRAMWEN  = r_dph_be;
        bus.SRAMADDR = r_dph_addr;
      end
    end
  end

  ahb_sram_wbuf #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wbuf (
    .i_clk        (HCLK),
    .i_rst        (HRESET),
    .i_load       (w_load),
    .i_commit     (w_commit),
    .i_addr       (r_dph_addr),
    .i_be         (r_dph_be),
    .i_data       (bus.HWDATA),
    .i_dph_rd     (r_dph_rd),
    .i_dph_addr   (r_dph_addr),
    .i_sram_rdata (bus.SRAMRDATA),
    .o_pend       (w_pend),
    .o_addr       (w_buf_addr),
    .o_be         (w_buf_be),
    .o_data       (w_buf_data),
    .o_rdata      (w_rdata)
  );

  assign bus.HRDATA    = HRESET ? '0 : w_rdata;
  assign bus.HREADYOUT = 1'b1;

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// Directed self-checking bench for ahb_sram_bridge with a behavioural SRAM.
module tb_ahb_sram_bridge;
  import ahb_pkg::*;

  localparam int unsigned AW = 12;

  logic HCLK;
  logic HRESET;
  int   checks;
  int   errors;
  logic [31:0] mem [0:(1<<AW)-1];

  ahb_sram_bridge_if #(.ADDR_WIDTH(AW)) bus ();

  ahb_sram_bridge #(.ADDR_WIDTH(AW)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Synchronous SRAM model: read data valid the cycle after a read strobe.
  always @(posedge HCLK) begin
    if (bus.SRAMCS0) begin
      if (bus.SRAMWEN == 4'h0) begin
        bus.SRAMRDATA <= mem[bus.SRAMADDR];
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (bus.SRAMWEN[i]) mem[bus.SRAMADDR][i*8 +: 8] <= bus.SRAMWDATA[i*8 +: 8];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ap(input logic sel, input logic [1:0] tr, input logic wr,
                    input logic [2:0] sz, input logic [31:0] a);
    bus.HSEL   = sel;
    bus.HTRANS = tr;
    bus.HWRITE = wr;
    bus.HSIZE  = sz;
    bus.HADDR  = a;
    bus.HREADY = 1'b1;
  endtask

  task automatic idle();
    ap(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
  endtask

  task automatic next();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    bus.SRAMRDATA = 32'h0;
    bus.HWDATA    = 32'h0;

    // Reset with an active read on the bus: port must stay quiet.
    HRESET = 1'b1;
    ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
    #2;
    chk("rst_cs",     32'(bus.SRAMCS0),   32'h0);
    chk("rst_wen",    32'(bus.SRAMWEN),   32'h0);
    chk("rst_addr",   32'(bus.SRAMADDR),  32'h0);
    chk("rst_rdata",  bus.HRDATA,         32'h0);
    chk("rst_hready", 32'(bus.HREADYOUT), 32'h1);
    next();
    next();

    // Word write then read back.
    HRESET = 1'b0;
    ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10);
    #2 chk("ww_aph_cs", 32'(bus.SRAMCS0), 32'h0);
    next();
    idle(); bus.HWDATA = 32'hDEADBEEF;
    #2;
    chk("ww_cs",    32'(bus.SRAMCS0),  32'h1);
    chk("ww_wen",   32'(bus.SRAMWEN),  32'hF);
    chk("ww_addr",  32'(bus.SRAMADDR), 32'h4);
    chk("ww_wdata", bus.SRAMWDATA,     32'hDEADBEEF);
    next();
    ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10); bus.HWDATA = 32'h0;
    #2;
    chk("wr_rd_cs",   32'(bus.SRAMCS0),  32'h1);
    chk("wr_rd_wen",  32'(bus.SRAMWEN),  32'h0);
    chk("wr_rd_addr", 32'(bus.SRAMADDR), 32'h4);
    next();
    idle();
    #2 chk("ww_rdata", bus.HRDATA, 32'hDEADBEEF);
    next();

    // Byte writes to 0x20..0x23, then read the assembled word.
    ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h20);
    next();
    ap(1'b1, HTRANS_SEQ, 1'b1, HSIZE_BYTE, 32'h21); bus.HWDATA = 32'h00000011;
    #2 chk("b0_wen", 32'(bus.SRAMWEN), 32'h1);
    next();
    ap(1'b1, HTRANS_SEQ, 1'b1, HSIZE_BYTE, 32'h22); bus.HWDATA = 32'h00002200;
    #2 chk("b1_wen", 32'(bus.SRAMWEN), 32'h2);
    next();
    ap(1'b1, HTRANS_SEQ, 1'b1, HSIZE_BYTE, 32'h23); bus.HWDATA = 32'h00330000;
    #2 chk("b2_wen", 32'(bus.SRAMWEN), 32'h4);
    next();
    idle(); bus.HWDATA = 32'h44000000;
    #2;
    chk("b3_wen",  32'(bus.SRAMWEN),  32'h8);
    chk("b3_addr", 32'(bus.SRAMADDR), 32'h8);
    next();
    ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20); bus.HWDATA = 32'h0;
    next();
    idle();
    #2 chk("b_rdata", bus.HRDATA, 32'h44332211);
    next();

    // Halfword write colliding with a read of the same word: buffer and merge.
    ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h32);
    next();
    ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h30); bus.HWDATA = 32'hABCD0000;
    #2;
    chk("hw_rd_cs",   32'(bus.SRAMCS0),  32'h1);
    chk("hw_rd_addr", 32'(bus.SRAMADDR), 32'hC);
    chk("hw_rd_wen",  32'(bus.SRAMWEN),  32'h0);
    next();
    idle(); bus.HWDATA = 32'h0;
    #2;
    chk("hw_merge",   bus.HRDATA,         32'hABCD0000);
    chk("hw_cm_wen",  32'(bus.SRAMWEN),   32'hC);
    chk("hw_cm_addr", 32'(bus.SRAMADDR),  32'hC);
    chk("hw_cm_data", bus.SRAMWDATA,      32'hABCD0000);
    next();
    #2;
    chk("hw_after_cs",    32'(bus.SRAMCS0), 32'h0);
    chk("hw_after_rdata", bus.HRDATA,       32'h0);
    next();
    ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h30);
    next();
    idle();
    #2 chk("hw_readback", bus.HRDATA, 32'hABCD0000);
    next();

    // Preload B and C, then write A, read B, read C, write D back-to-back.
    ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h44);
    next();
    ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h48); bus.HWDATA = 32'h0BBB0BBB;
    next();
    idle(); bus.HWDATA = 32'h0CCC0CCC;
    next();
    ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h40); bus.HWDATA = 32'h0;
    next();
    ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h44); bus.HWDATA = 32'hAAAAAAAA;
    #2;
    chk("bb_rb_cs",   32'(bus.SRAMCS0),   32'h1);
    chk("bb_rb_addr", 32'(bus.SRAMADDR),  32'h11);
    chk("bb_rb_wen",  32'(bus.SRAMWEN),   32'h0);
    chk("bb_hready1", 32'(bus.HREADYOUT), 32'h1);
    next();
    ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h48); bus.HWDATA = 32'h0;
    #2;
    chk("bb_rc_addr", 32'(bus.SRAMADDR), 32'h12);
    chk("bb_rc_wen",  32'(bus.SRAMWEN),  32'h0);
    chk("bb_b_data",  bus.HRDATA,        32'h0BBB0BBB);
    next();
    ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h4C);
    #2;
    chk("bb_cmA_wen",  32'(bus.SRAMWEN),   32'hF);
    chk("bb_cmA_addr", 32'(bus.SRAMADDR),  32'h10);
    chk("bb_cmA_data", bus.SRAMWDATA,      32'hAAAAAAAA);
    chk("bb_c_data",   bus.HRDATA,         32'h0CCC0CCC);
    chk("bb_hready2",  32'(bus.HREADYOUT), 32'h1);
    next();
    idle(); bus.HWDATA = 32'hDDDDDDDD;
    #2;
    chk("bb_wD_wen",  32'(bus.SRAMWEN),  32'hF);
    chk("bb_wD_addr", 32'(bus.SRAMADDR), 32'h13);
    chk("bb_wD_data", bus.SRAMWDATA,     32'hDDDDDDDD);
    next();
    ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h40); bus.HWDATA = 32'h0;
    next();
    idle();
    #2 chk("bb_a_readback", bus.HRDATA, 32'hAAAAAAAA);
    next();

    // Reset while a write is parked: it must be discarded.
    ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h50);
    next();
    ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h54); bus.HWDATA = 32'h55555555;
    next();
    HRESET = 1'b1;
    idle(); bus.HWDATA = 32'h0;
    #2;
    chk("prst_cs",    32'(bus.SRAMCS0),  32'h0);
    chk("prst_wen",   32'(bus.SRAMWEN),  32'h0);
    chk("prst_addr",  32'(bus.SRAMADDR), 32'h0);
    chk("prst_rdata", bus.HRDATA,        32'h0);
    next();
    HRESET = 1'b0;
    #2 chk("prst_after_cs", 32'(bus.SRAMCS0), 32'h0);
    next();
    ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h50);
    next();
    idle();
    #2 chk("prst_discard", bus.HRDATA, 32'h0);
    next();

    // Address aliasing and non-accepted transfers.
    ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h00004010);
    #2;
    chk("alias_cs",   32'(bus.SRAMCS0),  32'h1);
    chk("alias_addr", 32'(bus.SRAMADDR), 32'h4);
    next();
    ap(1'b1, HTRANS_BUSY, 1'b0, HSIZE_WORD, 32'h10);
    #2;
    chk("alias_rdata", bus.HRDATA,       32'hDEADBEEF);
    chk("busy_cs",     32'(bus.SRAMCS0), 32'h0);
    next();
    ap(1'b0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
    #2;
    chk("unsel_cs",   32'(bus.SRAMCS0), 32'h0);
    chk("busy_rdata", bus.HRDATA,       32'h0);
    next();
    ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10); bus.HREADY = 1'b0;
    #2 chk("nrdy_cs", 32'(bus.SRAMCS0), 32'h0);
    next();
    idle();
    #2 chk("nrdy_rdata", bus.HRDATA, 32'h0);
    next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
